// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: receive side of a toggle req/ack CDC handshake, delivering each word over valid/ready
module cdc_hs_rx #(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_t,
    input  logic [DATA_W-1:0] idata,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    input  logic              oready,
    output logic              ack_t,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic              proto_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_last_q, req_last_d;
    logic [DATA_W-1:0]      odata_q, odata_d;
    logic                   ovalid_q, ovalid_d;
    logic                   ack_t_q, ack_t_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic                   proto_err_q, proto_err_d;
    logic                   req_s, evt, busy, take, done;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign evt   = req_s ^ req_last_q;
    assign busy  = state_q == BUSY;
    assign take  = !busy && evt;
    assign done  = busy && ovalid_q && oready;

    // next state: capture on a new request edge, release and acknowledge once the word is taken
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], req_t};
        state_d     = take ? BUSY : done ? IDLE : state_q;
        req_last_d  = take ? req_s : req_last_q;
        odata_d     = take ? idata : odata_q;
        ovalid_d    = take || (ovalid_q && !done);
        ack_t_d     = ack_t_q ^ done;
        rx_cnt_d    = rx_cnt_q + CNT_W'(done);
        proto_err_d = proto_err_q || (busy && evt);
    end

    // all state clears the instant reset asserts so the sender sees ack return to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            req_last_q  <= 1'b0;
            odata_q     <= '0;
            ovalid_q    <= 1'b0;
            ack_t_q     <= 1'b0;
            rx_cnt_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            req_last_q  <= req_last_d;
            odata_q     <= odata_d;
            ovalid_q    <= ovalid_d;
            ack_t_q     <= ack_t_d;
            rx_cnt_q    <= rx_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign odata     = odata_q;
    assign ovalid    = ovalid_q;
    assign ack_t     = ack_t_q;
    assign rx_cnt    = rx_cnt_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_cdc_hs_rx.sv
// tb_cdc_hs_rx: directed checks of the toggle-handshake receiver
module tb_cdc_hs_rx;
    logic       clk, sclk, rst, req_t, oready, ovalid, ack_t, proto_err;
    logic [3:0] idata, odata;
    logic [7:0] rx_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       exp_ack;
    logic [7:0] exp_cnt;

    cdc_hs_rx #(.DATA_W(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_t(req_t), .idata(idata), .odata(odata), .ovalid(ovalid),
        .oready(oready), .ack_t(ack_t), .rx_cnt(rx_cnt), .proto_err(proto_err)
    );

    initial clk = 0;
    always #14 clk = ~clk;
    initial sclk = 0;
    always #5 sclk = ~sclk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1; req_t = 0; idata = 4'hA; oready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        exp_ack = 0; exp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if ({ovalid, ack_t, odata, rx_cnt, proto_err} !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d got ovalid=%b ack=%b odata=%h cnt=%0d perr=%b exp all 0",
                         i, ovalid, ack_t, odata, rx_cnt, proto_err);
            end
        end
    endtask

    task automatic test_basic();
        idata = 4'h5; oready = 1; req_t = ~req_t;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (ovalid !== (i == 2)) begin
                n_fail++;
                $display("FAIL basic_ovalid after edge k+%0d got %b exp %b", i, ovalid, (i == 2));
            end
            if (i == 2) begin
                n_tests++;
                if (odata !== 4'h5 || ack_t !== exp_ack) begin
                    n_fail++;
                    $display("FAIL basic_data got odata=%h ack=%b exp odata=5 ack=%b", odata, ack_t, exp_ack);
                end
            end
        end
        exp_ack = ~exp_ack; exp_cnt++;
        n_tests++;
        if (ack_t !== exp_ack || rx_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL basic_ack got ack=%b cnt=%0d exp ack=%b cnt=%0d", ack_t, rx_cnt, exp_ack, exp_cnt);
        end
    endtask

    task automatic test_stall();
        oready = 0; idata = 4'hC; req_t = ~req_t;
        repeat (2) @(negedge clk);
        n_tests++;
        if (ovalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_early got ovalid=%b exp 0", ovalid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (ovalid !== 1'b1 || odata !== 4'hC || ack_t !== exp_ack) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d got ovalid=%b odata=%h ack=%b exp 1 C %b",
                         i, ovalid, odata, ack_t, exp_ack);
            end
        end
        oready = 1;
        @(negedge clk);
        exp_ack = ~exp_ack; exp_cnt++;
        n_tests++;
        if (ovalid !== 1'b0 || ack_t !== exp_ack || rx_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL stall_release got ovalid=%b ack=%b cnt=%0d exp 0 %b %0d", ovalid, ack_t, rx_cnt, exp_ack, exp_cnt);
        end
    endtask

    task automatic test_proto_err();
        oready = 0; idata = 4'h3; req_t = ~req_t;
        repeat (3) @(negedge clk);
        n_tests++;
        if (ovalid !== 1'b1 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_pre got ovalid=%b perr=%b exp 1 0", ovalid, proto_err);
        end
        req_t = ~req_t;
        repeat (3) @(negedge clk);
        n_tests++;
        if (proto_err !== 1'b1 || odata !== 4'h3 || ovalid !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_set got perr=%b odata=%h ovalid=%b exp 1 3 1", proto_err, odata, ovalid);
        end
        idata = 4'h9; oready = 1;
        @(negedge clk);
        exp_ack = ~exp_ack; exp_cnt++;
        n_tests++;
        if (ovalid !== 1'b0 || ack_t !== exp_ack || rx_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL perr_deliver got ovalid=%b ack=%b cnt=%0d exp 0 %b %0d", ovalid, ack_t, rx_cnt, exp_ack, exp_cnt);
        end
        @(negedge clk);
        n_tests++;
        if (ovalid !== 1'b1 || odata !== 4'h9) begin
            n_fail++;
            $display("FAIL perr_extra_event got ovalid=%b odata=%h exp 1 9", ovalid, odata);
        end
        @(negedge clk);
        exp_ack = ~exp_ack; exp_cnt++;
        n_tests++;
        if (proto_err !== 1'b1 || ack_t !== exp_ack || rx_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL perr_sticky got perr=%b ack=%b cnt=%0d exp 1 %b %0d", proto_err, ack_t, rx_cnt, exp_ack, exp_cnt);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_still got %b exp 1", proto_err);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp_ack = 0; exp_cnt = 0;
        @(negedge clk);
        n_tests++;
        if (proto_err !== 1'b0 || rx_cnt !== 8'd0 || ack_t !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_clear got perr=%b cnt=%0d ack=%b exp 0 0 0", proto_err, rx_cnt, ack_t);
        end
    endtask

    task automatic test_stream();
        int got = 0;
        oready = 0;
        fork
            begin
                for (int w = 0; w < 16; w++) begin
                    int t = 0;
                    @(posedge sclk);
                    idata = 4'(w); req_t = ~req_t;
                    while (ack_t !== req_t && t < 300) begin
                        @(posedge sclk);
                        t++;
                    end
                    if (t >= 300) begin
                        n_tests++; n_fail++;
                        $display("FAIL stream_ack_timeout word %0d got ack=%b exp %b", w, ack_t, req_t);
                    end
                end
            end
            begin
                int cyc = 0;
                while (got < 16 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    oready = 1'($urandom_range(0, 1));
                    if (ovalid && oready) begin
                        n_tests++;
                        if (odata !== 4'(got) || odata !== idata) begin
                            n_fail++;
                            $display("FAIL stream_word %0d got %h exp %h (idata %h)", got, odata, 4'(got), idata);
                        end
                        got++;
                    end
                end
            end
        join
        repeat (2) @(negedge clk);
        oready = 0;
        n_tests++;
        if (got !== 16 || rx_cnt !== 8'd16 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_summary got words=%0d cnt=%0d perr=%b exp 16 16 0", got, rx_cnt, proto_err);
        end
    endtask

    task automatic test_async_reset();
        idata = 4'h6; oready = 1; req_t = ~req_t;
        repeat (4) @(negedge clk);
        oready = 0; idata = 4'h7; req_t = ~req_t;
        repeat (3) @(negedge clk);
        n_tests++;
        if (ovalid !== 1'b1 || ack_t !== 1'b1 || rx_cnt !== 8'd17 || odata !== 4'h7) begin
            n_fail++;
            $display("FAIL areset_pre got ovalid=%b ack=%b cnt=%0d odata=%h exp 1 1 17 7", ovalid, ack_t, rx_cnt, odata);
        end
        #5 rst = 1;
        #1;
        n_tests++;
        if (ovalid !== 1'b0 || ack_t !== 1'b0 || rx_cnt !== 8'd0 || odata !== 4'h0) begin
            n_fail++;
            $display("FAIL areset_immediate got ovalid=%b ack=%b cnt=%0d odata=%h exp 0 0 0 0", ovalid, ack_t, rx_cnt, odata);
        end
        @(negedge clk);
        rst = 0;
        exp_ack = 0; exp_cnt = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (ovalid !== 1'b0 || ack_t !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_quiet got ovalid=%b ack=%b exp 0 0", ovalid, ack_t);
        end
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_proto_err();
        test_stream();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
